// File: rtl/fitness_eval.sv
// Fitness evaluator: scores each chromosome against a target (matching bits, saturated),
// one per clock, then publishes a stable fitness array with best index and a done pulse.
module fitness_eval #(
   parameter int N       = 10,
   parameter int CHROM_W = 16,
   parameter int WIDTH   = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CHROM_W-1:0]     population [N],
   input  logic [CHROM_W-1:0]     target,
   output logic [WIDTH-1:0]       fitness_array [N],
   output logic [WIDTH-1:0]       best_fitness,
   output logic [$clog2(N)-1:0]   best_index,
   output logic                   perfect_found,
   output logic                   busy,
   output logic                   done
);

   localparam int IW      = $clog2(N);
   localparam int MAX_FIT = (1 << WIDTH) - 1;

   typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

   state_t               state;
   logic [IW-1:0]        idx;
   logic [CHROM_W-1:0]   snap [N];
   logic [CHROM_W-1:0]   snap_target;
   logic [WIDTH-1:0]     scratch [N];
   logic [WIDTH-1:0]     run_best;
   logic [IW-1:0]        run_idx;
   logic                 run_perfect;

   logic [CHROM_W-1:0]   diff;
   int                   fit_full;
   logic [WIDTH-1:0]     fit_sat;
   logic [WIDTH-1:0]     best_nxt;
   logic [IW-1:0]        best_idx_nxt;
   logic                 perfect_nxt;

   // NOTE: every signal gets a value before any condition, so no latch can be inferred.
   always_comb begin
      diff     = snap[idx] ^ snap_target;
      fit_full = CHROM_W - $countones(diff);
      if (fit_full > MAX_FIT) fit_sat = WIDTH'(MAX_FIT);
      else                    fit_sat = WIDTH'(fit_full);
      best_nxt     = run_best;
      best_idx_nxt = run_idx;
      perfect_nxt  = run_perfect | (fit_full == CHROM_W);
      // Strictly greater: on a tie the earlier index stays best.
      if (fit_sat > run_best) begin
         best_nxt     = fit_sat;
         best_idx_nxt = idx;
      end
   end

   // NOTE: snapshot and scratch are plain storage, always written before being read,
   // so they carry no reset and can map onto RAM-like resources.
   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         snap        <= population;
         snap_target <= target;
      end
      if (state == EVAL) scratch[idx] <= fit_sat;
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         idx           <= '0;
         run_best      <= '0;
         run_idx       <= '0;
         run_perfect   <= 1'b0;
         best_fitness  <= '0;
         best_index    <= '0;
         perfect_found <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         for (int i = 0; i < N; i++) fitness_array[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               idx         <= '0;
               run_best    <= '0;
               run_idx     <= '0;
               run_perfect <= 1'b0;
               state       <= EVAL;
            end
            EVAL: begin
               run_best    <= best_nxt;
               run_idx     <= best_idx_nxt;
               run_perfect <= perfect_nxt;
               if (idx == IW'(N - 1)) begin
                  // Results are published on entry to DONE so they are valid alongside done.
                  for (int i = 0; i < N; i++)
                     fitness_array[i] <= (i == N - 1) ? fit_sat : scratch[i];
                  best_fitness  <= best_nxt;
                  best_index    <= best_idx_nxt;
                  perfect_found <= perfect_nxt;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  state         <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fitness_eval.md
Name: fitness_eval

Overview:
- Upstream stage of the GA loop.
- Scores each chromosome of the current population against a target pattern and presents a stable N-entry fitness array plus a `done` strobe.
- That array and strobe feed the population sorter directly.
- One chromosome is evaluated per clock. The block also reports the best individual and a perfect-match flag for early termination.

Parameters:
- N, 10: population size (number of chromosomes).
- CHROM_W, 16: chromosome width in bits.
- WIDTH, 5: fitness value width; must match the sorter's WIDTH.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: request evaluation; sampled only in IDLE.
- population, input, N x CHROM_W: unpacked array of chromosomes, index 0..N-1.
- target, input, CHROM_W: reference pattern.
- fitness_array, output, N x WIDTH: fitness per chromosome, same index order as population.
- best_fitness, output, WIDTH: maximum fitness of the last completed run.
- best_index, output, $clog2(N): index of best_fitness.
- perfect_found, output, 1: last run contained a chromosome equal to target.
- busy, output, 1: high in LOAD and EVAL.
- done, output, 1: one-cycle pulse; results valid from this cycle.

Behaviour:
- Reset (rst=0, async): state=IDLE. fitness_array all 0, best_fitness=0, best_index=0, perfect_found=0, busy=0, done=0, internal index=0.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: register all of population and target into an internal snapshot; idx<=0; running best cleared to 0 / index 0 -> EVAL.
  - EVAL: one chromosome per cycle, idx 0..N-1. Compute fit[idx] into a scratch array. After idx=N-1 -> DONE.
  - DONE: copy scratch array to fitness_array, best registers to outputs; done=1 for exactly this cycle -> IDLE.
- Latency:
  - start sampled at edge k; LOAD during cycle k+1; EVAL cycles k+2..k+N+1; done high cycle k+N+2.
  - Total N+2 cycles from start edge to done.
- Fitness calculation:
  - fit = CHROM_W - popcount(chrom XOR target), computed at full width.
  - Saturate to 2^WIDTH-1 if it exceeds that value.
- Best tracking: strictly-greater compare, so ties keep the lowest index.
- perfect_found: set when any unsaturated fit == CHROM_W.
- Output stability:
  - fitness_array, best_*, perfect_found change only in the DONE cycle.
  - They hold until the next DONE or reset, so the sorter may sample on done or any later cycle.
- Input isolation: changes to population or target after LOAD have no effect on the current run.
- start outside IDLE (LOAD/EVAL/DONE): ignored and not queued. start held high continuously gives back-to-back runs, with one IDLE cycle between done and the next LOAD.
- Reset mid-run: immediate abort; outputs return to reset values; no done pulse.
- busy=0 in IDLE and DONE.

Test Plan:
- Reset: assert rst=0 during EVAL -> all outputs 0 immediately; after release, idle with done=0 indefinitely.
- Basic run: N=10, CHROM_W=16, target=16'hFFFF, population[i]=(1<<i)-1 -> fitness_array[i]=i, best_fitness=9, best_index=9, perfect_found=0; done exactly 12 cycles after start edge, one cycle wide.
- Perfect match and tie: population[3]=population[7]=target=16'hA5A5, others 16'h0000 -> fitness 16 at 3 and 7, 8 elsewhere; best_index=3, perfect_found=1.
- Saturation: CHROM_W=40, WIDTH=5, all chromosomes equal target -> every fitness_array entry = 31, perfect_found=1.
- Input isolation and start ignore:
  - Change population every cycle during EVAL -> results reflect the LOAD snapshot only.
  - start pulse during EVAL -> no second run.
- Back-to-back: hold start=1 for 30 cycles -> done pulses 13 cycles apart; fitness_array stable between pulses.
